// File: rtl/fixed_linear_bias_add.sv
// fixed_linear_bias_add
//
// Bias-add stage for a linear layer. One matmul result block and one bias
// block are joined: both are taken on the same edge, never one alone. Each
// lane then adds its bias after fixed-point alignment. The result is floored
// to the output fraction, saturated to the output word and queued in a
// 2-entry skid buffer. The final block of every tensor carries a last flag
// for the downstream activation/residual stage.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   data_in[N]      signed matmul lanes, N = P0*P1, index = row*P0 + col
//   data_in_valid   data block present
//   data_in_ready   data block taken this cycle if bias is also taken
//   bias[P0]        signed bias lanes, one per column
//   bias_valid      bias block present
//   bias_ready      bias block taken this cycle
//   data_out[N]     saturated result lanes (head of the skid buffer)
//   data_out_valid  skid buffer not empty
//   data_out_ready  downstream accepts the head entry
//   data_out_last   head entry is the final block of a tensor

module fixed_linear_bias_add #(
    parameter int DATA_IN_PRECISION_0       = 20,
    parameter int DATA_IN_PRECISION_1       = 6,
    parameter int BIAS_PRECISION_0          = 16,
    parameter int BIAS_PRECISION_1          = 3,
    parameter int DATA_OUT_PRECISION_0      = 16,
    parameter int DATA_OUT_PRECISION_1      = 3,
    parameter int DATA_IN_TENSOR_SIZE_DIM_0 = 32,
    parameter int DATA_IN_TENSOR_SIZE_DIM_1 = 16,
    parameter int DATA_IN_PARALLELISM_DIM_0 = 1,
    parameter int DATA_IN_PARALLELISM_DIM_1 = 1
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic [DATA_IN_PRECISION_0-1:0]  data_in [DATA_IN_PARALLELISM_DIM_0*DATA_IN_PARALLELISM_DIM_1],
    input  logic                            data_in_valid,
    output logic                            data_in_ready,

    input  logic [BIAS_PRECISION_0-1:0]     bias [DATA_IN_PARALLELISM_DIM_0],
    input  logic                            bias_valid,
    output logic                            bias_ready,

    output logic [DATA_OUT_PRECISION_0-1:0] data_out [DATA_IN_PARALLELISM_DIM_0*DATA_IN_PARALLELISM_DIM_1],
    output logic                            data_out_valid,
    input  logic                            data_out_ready,
    output logic                            data_out_last
);

    localparam int N_LANES = DATA_IN_PARALLELISM_DIM_0 * DATA_IN_PARALLELISM_DIM_1;
    localparam int DIN_W   = DATA_IN_PRECISION_0;
    localparam int BIAS_W  = BIAS_PRECISION_0;
    localparam int DOUT_W  = DATA_OUT_PRECISION_0;

    // Bias is moved up to the data fraction. The sum is then moved down to
    // the output fraction.
    localparam int SHIFT_B = DATA_IN_PRECISION_1 - BIAS_PRECISION_1;
    localparam int SHIFT_O = DATA_IN_PRECISION_1 - DATA_OUT_PRECISION_1;

    // One guard bit above the wider aligned operand makes the add exact.
    localparam int ALIGN_W = BIAS_W + SHIFT_B;
    localparam int SUM_W   = ((DIN_W > ALIGN_W) ? DIN_W : ALIGN_W) + 1;

    // The compare width covers both the shifted sum and the output format.
    // The extra bit keeps the saturation limits representable.
    localparam int CMP_W   = ((SUM_W > DOUT_W) ? SUM_W : DOUT_W) + 1;

    localparam logic signed [CMP_W-1:0] SAT_MAX = {{(CMP_W-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
    localparam logic signed [CMP_W-1:0] SAT_MIN = {{(CMP_W-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};

    // Block position within the tensor
    localparam int D0    = DATA_IN_TENSOR_SIZE_DIM_0 / DATA_IN_PARALLELISM_DIM_0;
    localparam int D1    = DATA_IN_TENSOR_SIZE_DIM_1 / DATA_IN_PARALLELISM_DIM_1;
    localparam int COL_W = (D0 > 1) ? $clog2(D0) : 1;
    localparam int ROW_W = (D1 > 1) ? $clog2(D1) : 1;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic [1:0] cnt_reg;
    logic [1:0] cnt_next;
    logic       room;
    logic       fire;
    logic       pop;

    // Room is taken from the registered count. A pop while full therefore
    // re-opens the inputs only in the following cycle.
    assign room           = (cnt_reg < 2'd2);
    assign data_in_ready  = bias_valid & room;
    assign bias_ready     = data_in_valid & room;
    assign fire           = data_in_valid & bias_valid & room;
    assign data_out_valid = (cnt_reg != 2'd0);
    assign pop            = data_out_valid & data_out_ready;

    // ------------------------------------------------------------------
    // Lane arithmetic
    // ------------------------------------------------------------------
    logic [DOUT_W-1:0] lane_res [N_LANES];

    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            localparam int BIDX = gi % DATA_IN_PARALLELISM_DIM_0;

            logic signed [SUM_W-1:0] din_ext;
            logic signed [SUM_W-1:0] bias_ext;
            logic signed [SUM_W-1:0] bias_al;
            logic signed [SUM_W-1:0] sum;
            logic signed [SUM_W-1:0] res;
            logic signed [CMP_W-1:0] res_ext;

            assign din_ext  = {{(SUM_W-DIN_W){data_in[gi][DIN_W-1]}}, data_in[gi]};
            assign bias_ext = {{(SUM_W-BIAS_W){bias[BIDX][BIAS_W-1]}}, bias[BIDX]};
            assign bias_al  = bias_ext <<< SHIFT_B;
            assign sum      = din_ext + bias_al;
            // An arithmetic right shift of a two's-complement value floors,
            // so the result rounds toward minus infinity.
            assign res      = sum >>> SHIFT_O;
            assign res_ext  = {{(CMP_W-SUM_W){res[SUM_W-1]}}, res};

            always_comb begin
                lane_res[gi] = res_ext[DOUT_W-1:0];
                if (res_ext > SAT_MAX) begin
                    lane_res[gi] = SAT_MAX[DOUT_W-1:0];
                end else if (res_ext < SAT_MIN) begin
                    lane_res[gi] = SAT_MIN[DOUT_W-1:0];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Tensor position counters
    // ------------------------------------------------------------------
    logic [COL_W-1:0] col_cnt_reg;
    logic [COL_W-1:0] col_cnt_next;
    logic [ROW_W-1:0] row_cnt_reg;
    logic [ROW_W-1:0] row_cnt_next;
    logic             col_last;
    logic             row_last;
    logic             new_last;

    assign col_last = (col_cnt_reg == COL_W'(D0 - 1));
    assign row_last = (row_cnt_reg == ROW_W'(D1 - 1));
    assign new_last = col_last & row_last;

    always_comb begin
        col_cnt_next = col_cnt_reg;
        row_cnt_next = row_cnt_reg;
        if (fire) begin
            if (col_last) begin
                col_cnt_next = '0;
                if (row_last) begin
                    row_cnt_next = '0;
                end else begin
                    row_cnt_next = row_cnt_reg + ROW_W'(1);
                end
            end else begin
                col_cnt_next = col_cnt_reg + COL_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Two-entry skid buffer
    // ------------------------------------------------------------------
    // The head is its own register and drives the outputs directly.
    // When the buffer drains, data_out keeps the last value shown.
    // The skid entry holds the second block while the head is stalled.
    logic [DOUT_W-1:0] head_reg  [N_LANES];
    logic [DOUT_W-1:0] head_next [N_LANES];
    logic              head_last_reg;
    logic              head_last_next;
    logic [DOUT_W-1:0] skid_reg  [N_LANES];
    logic [DOUT_W-1:0] skid_next [N_LANES];
    logic              skid_last_reg;
    logic              skid_last_next;

    always_comb begin
        cnt_next       = cnt_reg;
        head_next      = head_reg;
        head_last_next = head_last_reg;
        skid_next      = skid_reg;
        skid_last_next = skid_last_reg;
        case ({fire, pop})
            2'b10: begin
                cnt_next = cnt_reg + 2'd1;
                if (cnt_reg == 2'd0) begin
                    head_next      = lane_res;
                    head_last_next = new_last;
                end else begin
                    skid_next      = lane_res;
                    skid_last_next = new_last;
                end
            end
            2'b01: begin
                cnt_next = cnt_reg - 2'd1;
                if (cnt_reg == 2'd2) begin
                    head_next      = skid_reg;
                    head_last_next = skid_last_reg;
                end
            end
            2'b11: begin
                // Only possible with exactly one entry. The new block
                // replaces the departing head, and the count is unchanged.
                head_next      = lane_res;
                head_last_next = new_last;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg       <= 2'd0;
            head_reg      <= '{default: '0};
            head_last_reg <= 1'b0;
            skid_reg      <= '{default: '0};
            skid_last_reg <= 1'b0;
            col_cnt_reg   <= '0;
            row_cnt_reg   <= '0;
        end else begin
            cnt_reg       <= cnt_next;
            head_reg      <= head_next;
            head_last_reg <= head_last_next;
            skid_reg      <= skid_next;
            skid_last_reg <= skid_last_next;
            col_cnt_reg   <= col_cnt_next;
            row_cnt_reg   <= row_cnt_next;
        end
    end

    assign data_out      = head_reg;
    assign data_out_last = head_last_reg;

endmodule

// File: tb/tb_fixed_linear_bias_add.sv
// Testbench for fixed_linear_bias_add with two columns per block.
// This gives a 16 x 16 block tensor.
module tb_fixed_linear_bias_add;

    localparam int P0 = 2;
    localparam int P1 = 1;
    localparam int NL = P0 * P1;
    localparam int BLOCKS = (32 / P0) * (16 / P1);

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] data_in [NL];
    logic        data_in_valid;
    logic        data_in_ready;
    logic [15:0] bias [P0];
    logic        bias_valid;
    logic        bias_ready;
    logic [15:0] data_out [NL];
    logic        data_out_valid;
    logic        data_out_ready;
    logic        data_out_last;

    always #5 clk = ~clk;

    fixed_linear_bias_add #(
        .DATA_IN_PARALLELISM_DIM_0(P0),
        .DATA_IN_PARALLELISM_DIM_1(P1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .bias           (bias),
        .bias_valid     (bias_valid),
        .bias_ready     (bias_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .data_out_last  (data_out_last)
    );

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [15:0] e0;
        logic [15:0] e1;
        logic        last;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic: Q13.6 + (Q12.3 << 3), floor to Q.3, clamp to 16 bits
    function automatic logic [15:0] model(input logic [19:0] d, input logic [15:0] b);
        longint s;
        s = longint'($signed(d)) + longint'($signed(b)) * 8;
        s = s >>> 3;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s[15:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_check(input string tag,
                              input logic [19:0] d0, input logic [19:0] d1,
                              input logic [15:0] b0, input logic [15:0] b1,
                              input logic [15:0] e0, input logic [15:0] e1);
        data_in[0] = d0; data_in[1] = d1;
        bias[0] = b0;    bias[1] = b1;
        data_in_valid = 1'b1; bias_valid = 1'b1; data_out_ready = 1'b1;
        #1;
        chk({tag, "_din_ready"}, 32'(data_in_ready), 32'd1);
        chk({tag, "_bias_ready"}, 32'(bias_ready), 32'd1);
        @(posedge clk); #1;
        data_in_valid = 1'b0;
        chk({tag, "_valid"}, 32'(data_out_valid), 32'd1);
        chk({tag, "_lane0"}, 32'(data_out[0]), 32'(e0));
        chk({tag, "_lane1"}, 32'(data_out[1]), 32'(e1));
        chk({tag, "_last"}, 32'(data_out_last), 32'd0);
        $display("send %s: lane0=%h lane1=%h last=%0d", tag, data_out[0], data_out[1], data_out_last);
        tick();
    endtask

    logic [19:0] bp_d0 [4];
    logic [19:0] bp_d1 [4];
    logic [15:0] bp_b0 [4];
    logic [15:0] bp_b1 [4];

    initial begin
        int   acc;
        logic f;
        int   fired;
        logic hold;
        logic [15:0] prev0, prev1;
        logic prev_last;
        exp_t e;
        logic fire_m;
        int   cyc;

        rst = 1'b1;
        data_in_valid = 1'b0; bias_valid = 1'b1; data_out_ready = 1'b0;
        data_in[0] = '0; data_in[1] = '0; bias[0] = '0; bias[1] = '0;
        tick(); tick();
        chk("reset_valid", 32'(data_out_valid), 32'd0);
        chk("reset_last", 32'(data_out_last), 32'd0);
        chk("reset_lane0", 32'(data_out[0]), 32'd0);
        chk("reset_lane1", 32'(data_out[1]), 32'd0);
        chk("reset_din_ready", 32'(data_in_ready), 32'd1);
        chk("reset_bias_ready", 32'(bias_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_reset_valid", 32'(data_out_valid), 32'd0);

        // Directed arithmetic: 1.0+1.0=2.0, 1.0+2.0=3.0, negatives, floor, saturation
        send_check("basic", 20'd64, 20'd64, 16'd8, 16'd16, 16'h0010, 16'h0018);
        send_check("neg_floor", 20'hFFFC0, 20'hFFFFF, 16'hFFF8, 16'h0000, 16'hFFF0, 16'hFFFF);
        send_check("saturate", 20'h7FFFF, 20'h80000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000);
        send_check("frac_floor", 20'd7, 20'hFFFF7, 16'h0000, 16'h0000, 16'h0000, 16'hFFFE);

        // Only one side valid: nothing is taken
        data_in_valid = 1'b0; bias_valid = 1'b1; #1;
        chk("bias_only_bias_ready", 32'(bias_ready), 32'd0);
        tick();
        chk("bias_only_no_out", 32'(data_out_valid), 32'd0);
        data_in_valid = 1'b1; bias_valid = 1'b0; #1;
        chk("data_only_din_ready", 32'(data_in_ready), 32'd0);
        chk("data_only_bias_ready", 32'(bias_ready), 32'd1);
        tick();
        chk("data_only_no_out", 32'(data_out_valid), 32'd0);

        // Backpressure: four stalled cycles with continuous valid inputs
        for (int k = 0; k < 4; k++) begin
            bp_d0[k] = 20'(100 * k + 5);
            bp_d1[k] = 20'hFFF00 + 20'(k);
            bp_b0[k] = 16'(3 * k + 1);
            bp_b1[k] = 16'hFFF0 - 16'(k);
        end
        data_out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            data_in[0] = bp_d0[acc]; data_in[1] = bp_d1[acc];
            bias[0] = bp_b0[acc];    bias[1] = bp_b1[acc];
            data_in_valid = 1'b1; bias_valid = 1'b1;
            #1;
            f = data_in_ready;
            @(posedge clk); #1;
            if (f) acc++;
            chk("bp_stable_lane0", 32'(data_out[0]), 32'(model(bp_d0[0], bp_b0[0])));
            chk("bp_stable_lane1", 32'(data_out[1]), 32'(model(bp_d1[0], bp_b1[0])));
        end
        chk("bp_accepted", 32'(acc), 32'd2);
        chk("bp_din_ready_full", 32'(data_in_ready), 32'd0);
        chk("bp_bias_ready_full", 32'(bias_ready), 32'd0);
        chk("bp_valid_full", 32'(data_out_valid), 32'd1);
        data_in_valid = 1'b0;
        data_out_ready = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("bp_drain_valid", 32'(data_out_valid), 32'd1);
            chk("bp_drain_lane0", 32'(data_out[0]), 32'(model(bp_d0[k], bp_b0[k])));
            chk("bp_drain_lane1", 32'(data_out[1]), 32'(model(bp_d1[k], bp_b1[k])));
            $display("drain %0d: lane0=%h lane1=%h", k, data_out[0], data_out[1]);
            tick();
        end
        chk("bp_drain_empty", 32'(data_out_valid), 32'd0);

        // Reset mid-stream while the buffer is full
        data_out_ready = 1'b0;
        data_in_valid = 1'b1; bias_valid = 1'b1;
        tick(); tick();
        chk("midrst_full_ready", 32'(data_in_ready), 32'd0);
        chk("midrst_full_valid", 32'(data_out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", 32'(data_out_valid), 32'd0);
        chk("midrst_din_ready", 32'(data_in_ready), 32'd1);
        data_in_valid = 1'b0;
        tick();

        // Two full tensors with random stalls on both sides
        fired = 0; hold = 1'b0; prev0 = '0; prev1 = '0; prev_last = 1'b0;
        for (cyc = 0; cyc < 8000; cyc++) begin
            if (fired == 2 * BLOCKS && q.size() == 0) break;
            if (fired < 2 * BLOCKS) begin
                data_in_valid = ($urandom_range(0, 99) < 75);
                bias_valid    = ($urandom_range(0, 99) < 75);
            end else begin
                data_in_valid = 1'b0;
                bias_valid    = 1'b0;
            end
            data_in[0] = 20'($urandom); data_in[1] = 20'($urandom);
            bias[0] = 16'($urandom);    bias[1] = 16'($urandom);
            data_out_ready = ($urandom_range(0, 99) < 70);
            #1;
            if (hold) begin
                chk("tensor_hold_lane0", 32'(data_out[0]), 32'(prev0));
                chk("tensor_hold_lane1", 32'(data_out[1]), 32'(prev1));
                chk("tensor_hold_last", 32'(data_out_last), 32'(prev_last));
            end
            chk("tensor_din_ready", 32'(data_in_ready), 32'(bias_valid && q.size() < 2));
            chk("tensor_valid", 32'(data_out_valid), 32'(q.size() != 0));
            fire_m = data_in_valid && bias_valid && (q.size() < 2);
            if (data_out_valid && data_out_ready && q.size() != 0) begin
                e = q.pop_front();
                chk("tensor_lane0", 32'(data_out[0]), 32'(e.e0));
                chk("tensor_lane1", 32'(data_out[1]), 32'(e.e1));
                chk("tensor_last", 32'(data_out_last), 32'(e.last));
                if (e.last) $display("tensor end seen at cycle %0d", cyc);
            end
            if (fire_m) begin
                e.e0 = model(data_in[0], bias[0]);
                e.e1 = model(data_in[1], bias[1]);
                e.last = ((fired % BLOCKS) == BLOCKS - 1);
                q.push_back(e);
                fired++;
            end
            hold = data_out_valid && !data_out_ready;
            prev0 = data_out[0]; prev1 = data_out[1]; prev_last = data_out_last;
            @(posedge clk); #1;
        end
        chk("tensor_blocks_fired", 32'(fired), 32'(2 * BLOCKS));
        chk("tensor_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
